// File: rtl/fft16_stage_ctrl.sv
// Sequencer for the 16-point radix-4 FFT: stage 1 into the transpose buffer, stage 2 back through
// the shared butterfly with twiddles. Frame period is 4+BFLY_LAT+BUF_LAT-1+4+BFLY_LAT cycles.
module fft16_stage_ctrl #(
  parameter int BFLY_LAT = 1,
  parameter int BUF_LAT  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             buf_wr_flag,
  output logic             bfly_stage_sel,
  output logic             tw_en,
  output logic [1:0]       tw_addr,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int FILL_LEN = BFLY_LAT + BUF_LAT - 1;
  localparam int DW       = $clog2(FILL_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, ISSUE2, FLUSH} state_t;

  state_t            state;
  logic [1:0]        beat;
  logic [DW-1:0]     dcnt;
  logic              err;
  logic              issue1;
  logic [BFLY_LAT-1:0] wr_dl;
  logic [BFLY_LAT-1:0] ov_dl;
  logic [BFLY_LAT-1:0] ol_dl;

  // LOAD issues unconditionally so the buffer always sees four back-to-back write flags.
  assign issue1 = (state == IDLE && in_ready && in_valid) || (state == LOAD);

  assign buf_wr_flag = wr_dl[BFLY_LAT-1];
  assign out_valid   = ov_dl[BFLY_LAT-1];
  assign out_last    = ol_dl[BFLY_LAT-1];
  assign out_err     = out_valid & err;
  assign busy        = (state != IDLE) | (|wr_dl) | (|ov_dl) | (|ol_dl);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat           <= 2'd0;
      dcnt           <= '0;
      err            <= 1'b0;
      in_ready       <= 1'b0;
      bfly_stage_sel <= 1'b0;
      tw_en          <= 1'b0;
      tw_addr        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            state <= LOAD;
            beat  <= 2'd1;
          end
        end
        LOAD: begin
          if (!in_valid) err <= 1'b1;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state    <= FILL;
            in_ready <= 1'b0;
            dcnt     <= DW'(FILL_LEN - 1);
          end
        end
        FILL: begin
          if (dcnt == '0) begin
            state          <= ISSUE2;
            bfly_stage_sel <= 1'b1;
            tw_en          <= 1'b1;
            tw_addr        <= 2'd0;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        ISSUE2: begin
          tw_addr <= tw_addr + 2'd1;
          if (tw_addr == 2'd3) begin
            state          <= FLUSH;
            bfly_stage_sel <= 1'b0;
            tw_en          <= 1'b0;
            dcnt           <= DW'(BFLY_LAT - 1);
          end
        end
        FLUSH: begin
          if (dcnt == '0) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            err      <= 1'b0;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay lines model the butterfly pipeline so flags line up with result beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_dl     <= '0;
      ov_dl     <= '0;
      ol_dl     <= '0;
      frame_cnt <= '0;
    end else begin
      wr_dl[0] <= issue1;
      ov_dl[0] <= bfly_stage_sel;
      ol_dl[0] <= bfly_stage_sel && (tw_addr == 2'd3);
      for (int i = 1; i < BFLY_LAT; i++) begin
        wr_dl[i] <= wr_dl[i-1];
        ov_dl[i] <= ov_dl[i-1];
        ol_dl[i] <= ol_dl[i-1];
      end
      if (out_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// Scoreboard bench for fft16_stage_ctrl: instance 0 uses BFLY_LAT=1, instance 1 BFLY_LAT=3,
// both with a 2-bit frame counter so wrap-around is reachable.
module tb_fft16_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic       buf_wr_flag [2];
  logic       bfly_stage_sel [2];
  logic       tw_en [2];
  logic [1:0] tw_addr [2];
  logic       out_valid [2];
  logic       out_last [2];
  logic       out_err [2];
  logic       busy [2];
  logic [1:0] frame_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft16_stage_ctrl #(.BFLY_LAT((g == 0) ? 1 : 3), .BUF_LAT(2), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .buf_wr_flag(buf_wr_flag[g]), .bfly_stage_sel(bfly_stage_sel[g]), .tw_en(tw_en[g]),
      .tw_addr(tw_addr[g]), .out_valid(out_valid[g]), .out_last(out_last[g]),
      .out_err(out_err[g]), .busy(busy[g]), .frame_cnt(frame_cnt[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int d; int cyc; int val;} ev_t;
  typedef struct {int d; int cyc; int kind; int val;} probe_t;

  ev_t    q_wr[$];
  ev_t    q_tw[$];
  ev_t    q_out[$];
  probe_t q_pr[$];
  int     n_checks = 0;
  int     n_fails  = 0;
  bit     done     = 1'b0;

  function automatic int find(input ev_t q[$], input int d);
    for (int i = 0; i < q.size(); i++) if (q[i].d == d) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected beats whenever a DUT raises a flag, and evaluates timed probes.
  always @(negedge clk) begin
    int idx;
    int act;
    for (int d = 0; d < 2; d++) begin
      if (buf_wr_flag[d]) begin
        idx = find(q_wr, d);
        chk("wr_expected", d, int'(idx >= 0), 1);
        if (idx >= 0) begin
          chk("wr_cycle", d, cyc, q_wr[idx].cyc);
          q_wr.delete(idx);
        end
      end
      if (bfly_stage_sel[d]) begin
        idx = find(q_tw, d);
        chk("issue2_expected", d, int'(idx >= 0), 1);
        chk("tw_en", d, int'(tw_en[d]), 1);
        if (idx >= 0) begin
          chk("issue2_cycle", d, cyc, q_tw[idx].cyc);
          chk("tw_addr", d, int'(tw_addr[d]), q_tw[idx].val);
          q_tw.delete(idx);
        end
      end else if (tw_en[d]) begin
        chk("tw_en_idle", d, int'(tw_en[d]), 0);
      end
      if (out_valid[d]) begin
        idx = find(q_out, d);
        chk("out_expected", d, int'(idx >= 0), 1);
        if (idx >= 0) begin
          chk("out_cycle", d, cyc, q_out[idx].cyc);
          chk("out_last_err", d, int'({out_last[d], out_err[d]}), q_out[idx].val);
          q_out.delete(idx);
        end
      end else if (out_last[d] || out_err[d]) begin
        chk("framing_idle", d, int'({out_last[d], out_err[d]}), 0);
      end
    end
    for (int i = q_pr.size() - 1; i >= 0; i--) begin
      if (q_pr[i].cyc == cyc) begin
        case (q_pr[i].kind)
          0: act = int'(in_ready[q_pr[i].d]);
          1: act = int'(busy[q_pr[i].d]);
          2: act = int'(frame_cnt[q_pr[i].d]);
          default: act = int'({in_ready[q_pr[i].d], buf_wr_flag[q_pr[i].d],
                               bfly_stage_sel[q_pr[i].d], tw_en[q_pr[i].d], tw_addr[q_pr[i].d],
                               out_valid[q_pr[i].d], out_last[q_pr[i].d], out_err[q_pr[i].d],
                               busy[q_pr[i].d], frame_cnt[q_pr[i].d]});
        endcase
        chk($sformatf("probe_kind%0d", q_pr[i].kind), q_pr[i].d, act, q_pr[i].val);
        q_pr.delete(i);
      end
    end
    if (done) begin
      chk("wr_left", 0, q_wr.size(), 0);
      chk("issue2_left", 0, q_tw.size(), 0);
      chk("out_left", 0, q_out.size(), 0);
      chk("probe_left", 0, q_pr.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Expected beats of one frame accepted at a0; n2/nout allow truncation by a reset.
  task automatic push_frame(input int d, input int a0, input int lat, input int err,
                            input int n2, input int nout);
    for (int i = 0; i < 4; i++) q_wr.push_back('{d, a0 + lat + i, 0});
    for (int k = 0; k < n2; k++) q_tw.push_back('{d, a0 + lat + 5 + k, k});
    for (int k = 0; k < nout; k++)
      q_out.push_back('{d, a0 + 2*lat + 5 + k, ((k == 3) ? 2 : 0) + err});
  endtask

  task automatic probe(input int d, input int c, input int kind, input int val);
    q_pr.push_back('{d, c, kind, val});
  endtask

  task automatic drive(input int d, input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid[d] = pat[i];
      tick();
    end
    in_valid[d] = 1'b0;
  endtask

  initial begin
    int a0;
    rst_n    = '{1'b0, 1'b0};
    in_valid = '{1'b0, 1'b0};
    idle(3);
    rst_n = '{1'b1, 1'b1};
    probe(0, cyc, 3, 0);
    probe(1, cyc, 3, 0);
    probe(0, cyc + 1, 0, 1);
    probe(1, cyc + 1, 0, 1);
    idle(2);

    // single clean frame
    a0 = cyc;
    push_frame(0, a0, 1, 0, 4, 4);
    probe(0, a0 + 5, 0, 0);
    probe(0, a0 + 5, 1, 1);
    probe(0, a0 + 11, 0, 1);
    probe(0, a0 + 11, 1, 0);
    probe(0, a0 + 11, 2, 1);
    drive(0, 32'hF, 4);
    idle(10);

    // back-to-back frames with in_valid held high
    a0 = cyc;
    push_frame(0, a0, 1, 0, 4, 4);
    push_frame(0, a0 + 11, 1, 0, 4, 4);
    probe(0, a0 + 11, 0, 1);
    probe(0, a0 + 11, 2, 2);
    probe(0, a0 + 22, 2, 3);
    drive(0, 32'hFFFF_FFFF, 22);
    idle(3);

    // input gap on the third beat; frame counter wraps to 0
    a0 = cyc;
    push_frame(0, a0, 1, 1, 4, 4);
    probe(0, a0 + 11, 2, 0);
    drive(0, 32'hB, 4);
    idle(8);
    a0 = cyc;
    push_frame(0, a0, 1, 0, 4, 4);
    probe(0, a0 + 11, 2, 1);
    drive(0, 32'hF, 4);
    idle(10);

    // reset mid-frame during stage 2
    a0 = cyc;
    push_frame(0, a0, 1, 0, 2, 1);
    probe(0, a0 + 8, 3, 0);
    probe(0, a0 + 9, 0, 1);
    probe(0, a0 + 9, 1, 0);
    probe(0, a0 + 9, 2, 0);
    drive(0, 32'hF, 4);
    idle(3);
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    idle(3);

    // recovery frame after reset
    a0 = cyc;
    push_frame(0, a0, 1, 0, 4, 4);
    probe(0, a0 + 11, 2, 1);
    drive(0, 32'hF, 4);
    idle(10);

    // deeper butterfly: back-to-back at the 15-cycle minimum period
    a0 = cyc;
    push_frame(1, a0, 3, 0, 4, 4);
    push_frame(1, a0 + 15, 3, 0, 4, 4);
    probe(1, a0 + 14, 0, 0);
    probe(1, a0 + 15, 0, 1);
    probe(1, a0 + 30, 2, 2);
    drive(1, 32'hFFFF_FFFF, 30);
    idle(4);

    done = 1'b1;
    idle(3);
  end

endmodule
